seq_event_monitor: RTL and testbench

SEQ_EVENT_MONITOR -- requirements
Module: seq_event_monitor

---
 rtl/seq_event_monitor_if.sv | 31 +++
 rtl/seq_event_monitor.sv | 124 ++++++++++++
 tb/tb_seq_event_monitor.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_event_monitor_if.sv
// Event record stream between seq_event_monitor and its consumer.
//
// Handshake: ev_valid/ev_ready with strict valid/ready semantics. A record
// transfers on every rising clk edge where ev_valid && ev_ready. While
// ev_valid=1 and ev_ready=0 the producer holds ev_data stable, and once
// ev_valid is raised it stays up until the record is taken. ev_ready may
// be driven independently of ev_valid. ev_data is don't-care while ev_valid=0.
//
// Signals:
//   ev_valid  producer -> consumer  record available
//   ev_ready  consumer -> producer  consumer accepts record
//   ev_data   producer -> consumer  {type[1:0], timestamp[TS_W-1:0]}
interface seq_event_monitor_if #(
  parameter int TS_W = 12
);
  logic            ev_valid;
  logic            ev_ready;
  logic [TS_W+1:0] ev_data;

  modport master (
    output ev_valid,
    output ev_data,
    input  ev_ready
  );

  modport slave (
    input  ev_valid,
    input  ev_data,
    output ev_ready
  );
endinterface

// File: rtl/seq_event_monitor.sv
// seq_event_monitor: watches an upstream sequence detector (pulse z and
// one-hot state vector y), timestamps interesting events with a free-running
// counter and queues them in a small first-word-fall-through FIFO.
//
// Ports:
//   clk         clock, rising edge
//   reset       asynchronous, active-high reset
//   clr         synchronous clear of counters, sticky flags and FIFO
//   z           detection pulse from upstream detector
//   y[8:0]      one-hot detector state (bit0 = A ... bit8 = I)
//   ev          event record stream (master side of seq_event_monitor_if)
//   z_count     saturating count of z rising edges
//   onehot_err  sticky: y seen with popcount != 1
//   overflow    sticky: an event was dropped because the FIFO was full
//   fifo_level  current FIFO occupancy (0..DEPTH)
//
// Event types: 00 = invalid y entered, 11 = entered state I,
// 10 = entered state E, 01 = z rising edge. One push per cycle at most,
// highest type priority in that order.
module seq_event_monitor #(
  parameter int TS_W  = 12,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     z,
  input  logic [8:0]               y,
  seq_event_monitor_if.master      ev,
  output logic [7:0]               z_count,
  output logic                     onehot_err,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [TS_W-1:0] ts;
  logic            z_d;
  logic [8:0]      y_d;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [TS_W+1:0] mem [DEPTH];

  logic       y_ok;
  logic       y_d_ok;
  logic       err_c;
  logic       i_c;
  logic       e_c;
  logic       zrise_c;
  logic       push;
  logic [1:0] push_type;
  logic       full;
  logic       pop;
  logic       push_ok;

  assign y_ok    = ($countones(y) == 1);
  assign y_d_ok  = ($countones(y_d) == 1);
  // ERR fires only on the transition into an invalid vector, so a run of
  // invalid cycles produces a single record.
  assign err_c   = !y_ok && y_d_ok;
  assign i_c     = y[8] && !y_d[8];
  assign e_c     = y[4] && !y_d[4];
  assign zrise_c = z && !z_d;

  always_comb begin
    push      = 1'b1;
    push_type = 2'b00;
    if (err_c)        push_type = 2'b00;
    else if (i_c)     push_type = 2'b11;
    else if (e_c)     push_type = 2'b10;
    else if (zrise_c) push_type = 2'b01;
    else              push      = 1'b0;
  end

  assign full    = (fifo_level == LW'(DEPTH));
  assign pop     = ev.ev_valid && ev.ev_ready;
  // A pop in the same cycle frees the head slot, so a full FIFO still accepts.
  assign push_ok = push && (!full || pop);

  assign ev.ev_valid = (fifo_level != '0);
  assign ev.ev_data  = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts         <= '0;
      z_d        <= 1'b0;
      y_d        <= 9'b000000001;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      z_count    <= '0;
      onehot_err <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      ts  <= ts + 1'b1;
      z_d <= z;
      y_d <= y;
      if (clr) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_level <= '0;
        z_count    <= '0;
        onehot_err <= 1'b0;
        overflow   <= 1'b0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop)     rd_ptr <= rd_ptr + 1'b1;
        if (push_ok && !pop)      fifo_level <= fifo_level + 1'b1;
        else if (pop && !push_ok) fifo_level <= fifo_level - 1'b1;
        if (push && !push_ok) overflow <= 1'b1;
        if (zrise_c && (z_count != 8'hFF)) z_count <= z_count + 1'b1;
        if (!y_ok) onehot_err <= 1'b1;
      end
    end
  end

  // Storage needs no reset: entries are only visible once pointers say so.
  always_ff @(posedge clk) begin
    if (!clr && push_ok) mem[wr_ptr] <= {push_type, ts};
  end

endmodule

// File: tb/tb_seq_event_monitor.sv
module tb_seq_event_monitor;

  localparam int TS_W  = 12;
  localparam int DEPTH = 4;
  localparam int TS_MOD = 1 << TS_W;

  logic       clk;
  logic       reset;
  logic       clr;
  logic       z;
  logic [8:0] y;
  logic [7:0] z_count;
  logic       onehot_err;
  logic       overflow;
  logic [2:0] fifo_level;

  seq_event_monitor_if #(.TS_W(TS_W)) ev_bus ();

  seq_event_monitor #(.TS_W(TS_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .clr        (clr),
    .z          (z),
    .y          (y),
    .ev         (ev_bus),
    .z_count    (z_count),
    .onehot_err (onehot_err),
    .overflow   (overflow),
    .fifo_level (fifo_level)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard / reference model ----------------
  int n_tests = 0;
  int n_fail  = 0;

  logic [TS_W+1:0] exp_q[$];
  int              m_ts;
  logic            m_zd;
  logic [8:0]      m_yd;
  int              m_zc;
  logic            m_err;
  logic            m_ovf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int popcount9(input logic [8:0] v);
    int c = 0;
    for (int i = 0; i < 9; i++) if (v[i]) c++;
    return c;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_ts  = 0;
    m_zd  = 1'b0;
    m_yd  = 9'b000000001;
    m_zc  = 0;
    m_err = 1'b0;
    m_ovf = 1'b0;
  endtask

  // One clock of behaviour from the event rules: pick the highest priority
  // event, then apply consumer pop and producer push to the record queue.
  task automatic model_step(input logic zi, input logic [8:0] yi, input logic rdy, input logic c);
    bit       have_ev = 1'b1;
    bit [1:0] typ = 2'b00;
    int       pc  = popcount9(yi);
    int       pcd = popcount9(m_yd);
    if (pc != 1 && pcd == 1)      typ = 2'b00;
    else if (yi[8] && !m_yd[8])   typ = 2'b11;
    else if (yi[4] && !m_yd[4])   typ = 2'b10;
    else if (zi && !m_zd)         typ = 2'b01;
    else                          have_ev = 1'b0;
    if (c) begin
      exp_q.delete();
      m_zc  = 0;
      m_err = 1'b0;
      m_ovf = 1'b0;
    end else begin
      if (rdy && exp_q.size() > 0) void'(exp_q.pop_front());
      if (have_ev) begin
        if (exp_q.size() < DEPTH) exp_q.push_back({typ, TS_W'(m_ts)});
        else m_ovf = 1'b1;
      end
      if (zi && !m_zd && m_zc < 255) m_zc++;
      if (pc != 1) m_err = 1'b1;
    end
    m_zd = zi;
    m_yd = yi;
    m_ts = (m_ts + 1) % TS_MOD;
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_valid"},  ev_bus.ev_valid, (exp_q.size() != 0));
    check({tag, "_level"},  fifo_level, exp_q.size());
    check({tag, "_zcount"}, z_count, m_zc);
    check({tag, "_err"},    onehot_err, m_err);
    check({tag, "_ovf"},    overflow, m_ovf);
    if (exp_q.size() != 0) check({tag, "_data"}, ev_bus.ev_data, exp_q[0]);
  endtask

  // ---------------- driver ----------------
  // Called #1 after a rising edge; applies inputs for the coming edge and
  // compares outputs #1 after it.
  task automatic cycle(input logic zi, input logic [8:0] yi, input logic rdy, input logic c,
                       input string tag);
    z = zi;
    y = yi;
    ev_bus.ev_ready = rdy;
    clr = c;
    model_step(zi, yi, rdy, c);
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic            z;
    logic [8:0]      y;
    logic            rdy;
    logic            clr;
    logic            exp_valid;
    logic [TS_W+1:0] exp_data;
    logic [2:0]      exp_level;
    logic [7:0]      exp_zc;
    logic            exp_err;
    logic            exp_ovf;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic zi, input logic [8:0] yi, input logic rdy, input logic c,
                     input logic v, input logic [TS_W+1:0] d, input logic [2:0] lvl,
                     input logic [7:0] zc, input logic err, input logic ovf);
    vec_t r;
    r.z = zi; r.y = yi; r.rdy = rdy; r.clr = c;
    r.exp_valid = v; r.exp_data = d; r.exp_level = lvl;
    r.exp_zc = zc; r.exp_err = err; r.exp_ovf = ovf;
    tbl.push_back(r);
  endtask

  initial begin
    logic [8:0] yr;

    // Rows start right after reset release: row k is the cycle with ts=k.
    for (int k = 0; k < 5; k++)
      add(0, 9'h001, 0, 0,  0, 14'h0000, 0, 0, 0, 0);
    add(1, 9'h001, 0, 0,  1, 14'h1005, 1, 1, 0, 0);   // z rise at ts=5
    for (int k = 6; k < 10; k++)
      add(0, 9'h001, 1, 0,  0, 14'h0000, 0, 1, 0, 0);
    add(1, 9'h010, 1, 0,  1, 14'h200A, 1, 2, 0, 0);   // A->E with z rise: E wins
    add(0, 9'h010, 1, 0,  0, 14'h0000, 0, 2, 0, 0);
    add(0, 9'h011, 0, 0,  1, 14'h000C, 1, 2, 1, 0);   // invalid y -> ERR record
    add(0, 9'h011, 0, 0,  1, 14'h000C, 1, 2, 1, 0);   // still invalid: no 2nd record
    add(0, 9'h001, 0, 1,  0, 14'h0000, 0, 0, 0, 0);   // clr
    add(0, 9'h001, 0, 0,  0, 14'h0000, 0, 0, 0, 0);
    add(0, 9'h100, 0, 0,  1, 14'h3010, 1, 0, 0, 0);   // enter I
    add(1, 9'h100, 0, 0,  1, 14'h3010, 2, 1, 0, 0);   // z rise queued behind
    add(0, 9'h100, 1, 0,  1, 14'h1011, 1, 1, 0, 0);
    add(0, 9'h100, 1, 0,  0, 14'h0000, 0, 1, 0, 0);

    reset = 1'b1;
    clr = 1'b0;
    z = 1'b0;
    y = 9'h001;
    ev_bus.ev_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid",  ev_bus.ev_valid, 0);
    check("rst_level",  fifo_level, 0);
    check("rst_zcount", z_count, 0);
    check("rst_err",    onehot_err, 0);
    check("rst_ovf",    overflow, 0);
    reset = 1'b0;
    model_reset();

    for (int i = 0; i < tbl.size(); i++) begin
      string tg = $sformatf("tbl%0d", i);
      cycle(tbl[i].z, tbl[i].y, tbl[i].rdy, tbl[i].clr, tg);
      check({tg, "_xvalid"}, ev_bus.ev_valid, tbl[i].exp_valid);
      check({tg, "_xlevel"}, fifo_level, tbl[i].exp_level);
      check({tg, "_xzc"},    z_count, tbl[i].exp_zc);
      check({tg, "_xerr"},   onehot_err, tbl[i].exp_err);
      check({tg, "_xovf"},   overflow, tbl[i].exp_ovf);
      if (tbl[i].exp_valid) check({tg, "_xdata"}, ev_bus.ev_data, tbl[i].exp_data);
    end

    // Overflow: five z rises with consumer stalled, then drain in order.
    for (int i = 0; i < 5; i++) begin
      cycle(1, 9'h001, 0, 0, "ovf_push");
      cycle(0, 9'h001, 0, 0, "ovf_gap");
    end
    check("ovf_level_full", fifo_level, 4);
    check("ovf_sticky",     overflow, 1);
    for (int i = 0; i < 4; i++) cycle(0, 9'h001, 1, 0, "ovf_drain");
    check("ovf_drained", fifo_level, 0);
    check("ovf_held",    overflow, 1);

    // z_count saturation.
    cycle(0, 9'h001, 1, 1, "sat_clr");
    for (int i = 0; i < 300; i++) begin
      cycle(1, 9'h001, 1, 0, "sat_rise");
      cycle(0, 9'h001, 1, 0, "sat_low");
    end
    check("sat_zcount", z_count, 255);

    // Timestamp wrap.
    while (m_ts != TS_MOD - 2) cycle(0, 9'h001, 1, 0, "wrap_idle");
    cycle(1, 9'h001, 0, 0, "wrap_4094");
    cycle(0, 9'h001, 0, 0, "wrap_4095");
    cycle(1, 9'h001, 0, 0, "wrap_0");
    check("wrap_level", fifo_level, 2);
    check("wrap_head",  ev_bus.ev_data, 14'h1FFE);
    cycle(0, 9'h001, 1, 0, "wrap_pop");
    check("wrap_ts0",   ev_bus.ev_data, 14'h1000);

    // Asynchronous reset with three records queued.
    cycle(0, 9'h001, 0, 1, "ar_clr");
    for (int i = 0; i < 3; i++) begin
      cycle(1, 9'h001, 0, 0, "ar_fill");
      cycle(0, 9'h001, 0, 0, "ar_gap");
    end
    check("ar_level3", fifo_level, 3);
    #1;
    reset = 1'b1;
    #1;
    check("ar_valid_now", ev_bus.ev_valid, 0);
    check("ar_level_now", fifo_level, 0);
    #1;
    reset = 1'b0;
    model_reset();
    cycle(1, 9'h001, 0, 0, "ar_first");
    check("ar_first_ts", ev_bus.ev_data, 14'h1000);

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 9) == 0) yr = 9'($urandom_range(0, 511));
      else yr = 9'b1 << $urandom_range(0, 8);
      cycle(1'($urandom_range(0, 1)), yr, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 49) == 0), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
